hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage core. It sits beside the decode stage and watches register indices and control bits in ID, EX, MEM and WB. It generates the write-enable, flush and hold controls for the PC and the pipeline registers, and the operand forwarding selects for EX. It serialises load-use stalls, taken-branch flushes and data-memory wait holds through one small state machine.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/hazard_ctrl_fwd_unit.sv | 29 ++
 rtl/hazard_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
//   hz_state_t : controller states RUN / LDUSE / FLUSH / MEMWAIT (2-bit encoding)
//   FWD_*      : EX operand forwarding select codes
//   REG_W      : default register index width
package hazard_pkg;

    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDUSE   = 2'd1,
        FLUSH   = 2'd2,
        MEMWAIT = 2'd3
    } hz_state_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// fwd_unit: combinational forwarding select for one EX source operand.
//   ex_rs              in  source register index held in ID/EX
//   mem_rd / mem_regwr in  EX/MEM destination and write enable
//   wb_rd / wb_regwr   in  MEM/WB destination and write enable
//   fwd                out FWD_EXMEM, FWD_MEMWB or FWD_RF
// The younger EX/MEM result takes precedence; register 0 never forwards.
module fwd_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W = hazard_pkg::REG_W
) (
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_regwr,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_regwr,
    output logic [1:0]       fwd
);

    always_comb begin
        fwd = FWD_RF;
        if (mem_regwr && (mem_rd != '0) && (mem_rd == ex_rs)) begin
            fwd = FWD_EXMEM;
        end else if (wb_regwr && (wb_rd != '0) && (wb_rd == ex_rs)) begin
            fwd = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and sequencing controller for the 5-stage core.
// Serialises load-use stalls, taken-branch flushes and data-memory wait holds
// through one state machine, and produces the EX forwarding selects.
//   clk, rst (async, active-high)
//   d_rs1, d_rs2, d_uses_rs2          ID source operands
//   ex_rs1, ex_rs2, ex_memrd, ex_rd   ID/EX sources, load flag, destination
//   ex_branch_taken                    branch resolved taken in EX
//   mem_rd/mem_regwr, wb_rd/wb_regwr   later-stage destinations
//   mem_busy                           data memory not ready (freeze pipe)
//   pc_wr_en, ifid_wr_en, ifid_flush, idex_flush, pipe_hold   pipeline controls
//   fwd_a, fwd_b                       EX operand selects
//   hz_state                           current state (debug)
// Optional build macro HAZARD_PERF_EN adds saturating counters
//   stall_cnt (load-use entries), flush_cnt (ifid_flush cycles),
//   mwait_cnt (pipe_hold cycles).
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W        = hazard_pkg::REG_W,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] d_rs1,
    input  logic [REG_W-1:0] d_rs2,
    input  logic             d_uses_rs2,
    input  logic [REG_W-1:0] ex_rs1,
    input  logic [REG_W-1:0] ex_rs2,
    input  logic             ex_memrd,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_branch_taken,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_regwr,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_regwr,
    input  logic             mem_busy,
    output logic             pc_wr_en,
    output logic             ifid_wr_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_hold,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       hz_state
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      flush_cnt,
    output logic [31:0]      mwait_cnt
`endif
);

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    hz_state_t  state, state_nx;
    logic [2:0] cnt, cnt_nx;
    logic       branch_pend, branch_pend_nx;

    logic       pc_c, ifid_wr_c, ifid_fl_c, idex_fl_c, hold_c, lu_enter;
    logic       load_use;
    logic [1:0] fwd_a_c, fwd_b_c;

    assign load_use = ex_memrd && (ex_rd != '0) &&
                      ((ex_rd == d_rs1) || (d_uses_rs2 && (ex_rd == d_rs2)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            cnt         <= '0;
            branch_pend <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            branch_pend <= branch_pend_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt;
        branch_pend_nx = branch_pend;
        pc_c           = 1'b1;
        ifid_wr_c      = 1'b1;
        ifid_fl_c      = 1'b0;
        idex_fl_c      = 1'b0;
        hold_c         = 1'b0;
        lu_enter       = 1'b0;

        unique case (state)
            RUN, LDUSE: begin
                if (mem_busy) begin
                    pc_c           = 1'b0;
                    ifid_wr_c      = 1'b0;
                    hold_c         = 1'b1;
                    branch_pend_nx = ex_branch_taken;
                    state_nx       = MEMWAIT;
                end else if (ex_branch_taken) begin
                    ifid_fl_c = 1'b1;
                    idex_fl_c = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        cnt_nx   = FLUSH_INIT;
                        state_nx = FLUSH;
                    end else begin
                        state_nx = RUN;
                    end
                end else if ((state == RUN) && load_use) begin
                    // The LDUSE cycle masks detection so the same load
                    // cannot stall the consumer twice.
                    pc_c      = 1'b0;
                    ifid_wr_c = 1'b0;
                    idex_fl_c = 1'b1;
                    lu_enter  = 1'b1;
                    state_nx  = LDUSE;
                end else begin
                    state_nx = RUN;
                end
            end

            FLUSH: begin
                ifid_fl_c = 1'b1;
                idex_fl_c = 1'b1;
                if (mem_busy) begin
                    // Whole pipe frozen; the flush window resumes afterwards.
                    pc_c      = 1'b0;
                    ifid_wr_c = 1'b0;
                    hold_c    = 1'b1;
                end else begin
                    cnt_nx = cnt - 3'd1;
                    if (cnt <= 3'd1) begin
                        state_nx = RUN;
                    end
                end
            end

            MEMWAIT: begin
                if (mem_busy) begin
                    pc_c      = 1'b0;
                    ifid_wr_c = 1'b0;
                    hold_c    = 1'b1;
                end else if (branch_pend) begin
                    // Replay the branch that was caught behind the wait.
                    ifid_fl_c      = 1'b1;
                    idex_fl_c      = 1'b1;
                    branch_pend_nx = 1'b0;
                    if (FLUSH_CYCLES > 1) begin
                        cnt_nx   = FLUSH_INIT;
                        state_nx = FLUSH;
                    end else begin
                        state_nx = RUN;
                    end
                end else begin
                    state_nx = RUN;
                end
            end

            default: state_nx = RUN;
        endcase
    end

    fwd_unit #(.REG_W(REG_W)) u_fwd_a (
        .ex_rs     (ex_rs1),
        .mem_rd    (mem_rd),
        .mem_regwr (mem_regwr),
        .wb_rd     (wb_rd),
        .wb_regwr  (wb_regwr),
        .fwd       (fwd_a_c)
    );

    fwd_unit #(.REG_W(REG_W)) u_fwd_b (
        .ex_rs     (ex_rs2),
        .mem_rd    (mem_rd),
        .mem_regwr (mem_regwr),
        .wb_rd     (wb_rd),
        .wb_regwr  (wb_regwr),
        .fwd       (fwd_b_c)
    );

    // Reset overrides the controls combinationally so the pipe is held
    // flushed for as long as rst is high, not just from the next edge.
    always_comb begin
        if (rst) begin
            pc_wr_en   = 1'b0;
            ifid_wr_en = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            pipe_hold  = 1'b0;
            fwd_a      = FWD_RF;
            fwd_b      = FWD_RF;
        end else begin
            pc_wr_en   = pc_c;
            ifid_wr_en = ifid_wr_c;
            ifid_flush = ifid_fl_c;
            idex_flush = idex_fl_c;
            pipe_hold  = hold_c;
            fwd_a      = fwd_a_c;
            fwd_b      = fwd_b_c;
        end
    end

    assign hz_state = state;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            mwait_cnt <= '0;
        end else begin
            if (lu_enter && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
            if (ifid_fl_c && (flush_cnt != '1)) flush_cnt <= flush_cnt + 32'd1;
            if (hold_c && (mwait_cnt != '1)) mwait_cnt <= mwait_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: self-checking bench for hazard_ctrl (REG_W=5, FLUSH_CYCLES=2).
// Directed scenarios plus a randomized run against a cycle-level reference
// model expressed as "remaining flush cycles / waiting / pending branch".
// Build with HAZARD_PERF_EN defined to also check the perf counters.
module tb_hazard_ctrl;

    localparam int RW = 5;
    localparam int FC = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [RW-1:0] d_rs1, d_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic          d_uses_rs2, ex_memrd, ex_branch_taken, mem_regwr, wb_regwr, mem_busy;
    logic          pc_wr_en, ifid_wr_en, ifid_flush, idex_flush, pipe_hold;
    logic [1:0]    fwd_a, fwd_b, hz_state;
`ifdef HAZARD_PERF_EN
    logic [31:0]   stall_cnt, flush_cnt, mwait_cnt;
`endif

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.REG_W(RW), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst),
        .d_rs1(d_rs1), .d_rs2(d_rs2), .d_uses_rs2(d_uses_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_memrd(ex_memrd), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken),
        .mem_rd(mem_rd), .mem_regwr(mem_regwr), .wb_rd(wb_rd), .wb_regwr(wb_regwr),
        .mem_busy(mem_busy),
        .pc_wr_en(pc_wr_en), .ifid_wr_en(ifid_wr_en), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .pipe_hold(pipe_hold),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .hz_state(hz_state)
`ifdef HAZARD_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mwait_cnt(mwait_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: pipeline situation described by how many flush cycles
    // remain, whether the pipe waits on memory, whether a branch is parked
    // behind that wait, and whether last cycle was a load-use bubble.
    int   m_flush_left, n_flush_left;
    bit   m_wait, n_wait, m_pend, n_pend, m_shadow, n_shadow, lu_entry;
    int   m_stall, m_flushc, m_holdc;
    logic e_pc, e_ifid, e_iff, e_idf, e_hold;
    logic [1:0] e_state, e_fa, e_fb;

    function automatic logic [1:0] fwd_ref(input logic [RW-1:0] rs);
        if (mem_regwr && mem_rd != 0 && mem_rd == rs) return 2'b10;
        if (wb_regwr && wb_rd != 0 && wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_flush_left = 0; m_wait = 0; m_pend = 0; m_shadow = 0;
        m_stall = 0; m_flushc = 0; m_holdc = 0;
    endtask

    task automatic model_eval();
        bit lu;
        lu = ex_memrd && ex_rd != 0 && (ex_rd == d_rs1 || (d_uses_rs2 && ex_rd == d_rs2));
        e_pc = 1; e_ifid = 1; e_iff = 0; e_idf = 0; e_hold = 0;
        e_state = m_wait ? 2'd3 : (m_flush_left > 0) ? 2'd2 : m_shadow ? 2'd1 : 2'd0;
        n_flush_left = m_flush_left; n_wait = m_wait; n_pend = m_pend; n_shadow = 0; lu_entry = 0;
        if (m_wait) begin
            if (mem_busy) begin e_pc = 0; e_ifid = 0; e_hold = 1; end
            else begin
                n_wait = 0;
                if (m_pend) begin e_iff = 1; e_idf = 1; n_flush_left = FC - 1; n_pend = 0; end
            end
        end else if (m_flush_left > 0) begin
            e_iff = 1; e_idf = 1;
            if (mem_busy) begin e_pc = 0; e_ifid = 0; e_hold = 1; end
            else n_flush_left = m_flush_left - 1;
        end else begin
            if (mem_busy) begin e_pc = 0; e_ifid = 0; e_hold = 1; n_wait = 1; n_pend = ex_branch_taken; end
            else if (ex_branch_taken) begin e_iff = 1; e_idf = 1; n_flush_left = FC - 1; end
            else if (!m_shadow && lu) begin e_pc = 0; e_ifid = 0; e_idf = 1; n_shadow = 1; lu_entry = 1; end
        end
        e_fa = fwd_ref(ex_rs1);
        e_fb = fwd_ref(ex_rs2);
    endtask

    // Inputs are applied at the falling edge; outputs are sampled 1 time unit later.
    task automatic apply();
        #1 model_eval();
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        m_flush_left = n_flush_left; m_wait = n_wait; m_pend = n_pend; m_shadow = n_shadow;
        if (lu_entry) m_stall++;
        if (e_iff) m_flushc++;
        if (e_hold) m_holdc++;
        @(negedge clk);
    endtask

    task automatic set_idle();
        d_rs1 = 0; d_rs2 = 0; d_uses_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_memrd = 0;
        ex_rd = 0; ex_branch_taken = 0; mem_rd = 0; mem_regwr = 0; wb_rd = 0;
        wb_regwr = 0; mem_busy = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        set_idle();
        ex_memrd = 1; ex_rd = 5; d_rs1 = 5; ex_rs1 = 6; mem_rd = 6; mem_regwr = 1;
        ex_rs2 = 4; wb_rd = 4; wb_regwr = 1;
        #1;
        checks++; if (pc_wr_en !== 1'b0) begin errors++; $display("FAIL reset_pc: got %b want 0", pc_wr_en); end
        checks++; if (ifid_wr_en !== 1'b0) begin errors++; $display("FAIL reset_ifid_wr: got %b want 0", ifid_wr_en); end
        checks++; if (ifid_flush !== 1'b1 || idex_flush !== 1'b1) begin errors++; $display("FAIL reset_flush: got %b%b want 11", ifid_flush, idex_flush); end
        checks++; if (pipe_hold !== 1'b0) begin errors++; $display("FAIL reset_hold: got %b want 0", pipe_hold); end
        checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin errors++; $display("FAIL reset_fwd: got %b %b want 00 00", fwd_a, fwd_b); end
        checks++; if (hz_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", hz_state); end
        @(negedge clk);
        rst = 0; set_idle(); model_reset();
    endtask

    task automatic test_load_use();
        set_idle(); ex_memrd = 1; ex_rd = 5; d_rs1 = 5; apply();
        checks++; if ({pc_wr_en, ifid_wr_en, idex_flush, ifid_flush} !== 4'b0010) begin errors++; $display("FAIL lu_stall: got pc/ifid/idexf/ifidf=%b%b%b%b want 0010", pc_wr_en, ifid_wr_en, idex_flush, ifid_flush); end
        tick(); apply();
        checks++; if (hz_state !== 2'd1) begin errors++; $display("FAIL lu_state: got %0d want 1", hz_state); end
        checks++; if ({pc_wr_en, ifid_wr_en, idex_flush} !== 3'b110) begin errors++; $display("FAIL lu_bubble_out: got %b%b%b want 110", pc_wr_en, ifid_wr_en, idex_flush); end
        tick(); set_idle(); apply();
        checks++; if (hz_state !== 2'd0) begin errors++; $display("FAIL lu_return: got %0d want 0", hz_state); end
        tick();
    endtask

    task automatic test_branch();
        set_idle(); ex_branch_taken = 1; apply();
        checks++; if ({ifid_flush, idex_flush, pc_wr_en} !== 3'b111) begin errors++; $display("FAIL br_cycle1: got %b%b%b want 111", ifid_flush, idex_flush, pc_wr_en); end
        tick(); ex_branch_taken = 0; apply();
        checks++; if (hz_state !== 2'd2 || {ifid_flush, idex_flush, pc_wr_en} !== 3'b111) begin errors++; $display("FAIL br_cycle2: got state %0d out %b%b%b want 2 111", hz_state, ifid_flush, idex_flush, pc_wr_en); end
        tick(); apply();
        checks++; if (hz_state !== 2'd0 || ifid_flush !== 1'b0) begin errors++; $display("FAIL br_done: got state %0d flush %b want 0 0", hz_state, ifid_flush); end
        tick();
    endtask

    task automatic test_branch_busy();
        set_idle(); ex_branch_taken = 1; mem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            apply();
            checks++; if (pipe_hold !== 1'b1 || pc_wr_en !== 1'b0 || ifid_flush !== 1'b0) begin errors++; $display("FAIL bb_hold%0d: got hold %b pc %b flush %b want 1 0 0", i, pipe_hold, pc_wr_en, ifid_flush); end
            tick(); ex_branch_taken = 0;
        end
        mem_busy = 0;
        for (int i = 0; i < 2; i++) begin
            apply();
            checks++; if (ifid_flush !== 1'b1 || idex_flush !== 1'b1 || pipe_hold !== 1'b0) begin errors++; $display("FAIL bb_flush%0d: got %b%b hold %b want 11 0", i, ifid_flush, idex_flush, pipe_hold); end
            tick();
        end
        apply();
        checks++; if (hz_state !== 2'd0 || ifid_flush !== 1'b0) begin errors++; $display("FAIL bb_end: got state %0d flush %b want 0 0", hz_state, ifid_flush); end
        // A later wait with no branch must not replay the old one.
        mem_busy = 1; tick(); mem_busy = 0; apply();
        checks++; if (hz_state !== 2'd3 || ifid_flush !== 1'b0) begin errors++; $display("FAIL bb_pend_clear: got state %0d flush %b want 3 0", hz_state, ifid_flush); end
        tick();
    endtask

    task automatic test_forwarding();
        set_idle(); ex_rs1 = 7; mem_rd = 7; mem_regwr = 1; wb_rd = 7; wb_regwr = 1; apply();
        checks++; if (fwd_a !== 2'b10) begin errors++; $display("FAIL fwd_exmem_wins: got %b want 10", fwd_a); end
        ex_rs1 = 1; ex_rs2 = 7; mem_rd = 3; apply();
        checks++; if (fwd_b !== 2'b01 || fwd_a !== 2'b00) begin errors++; $display("FAIL fwd_memwb: got b=%b a=%b want 01 00", fwd_b, fwd_a); end
        ex_rs1 = 0; ex_rs2 = 0; mem_rd = 0; wb_rd = 0; apply();
        checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin errors++; $display("FAIL fwd_r0: got %b %b want 00 00", fwd_a, fwd_b); end
        ex_rs1 = 9; mem_rd = 9; mem_regwr = 0; wb_rd = 9; wb_regwr = 0; apply();
        checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL fwd_nowr: got %b want 00", fwd_a); end
        set_idle(); apply();
    endtask

    task automatic test_reg0();
        set_idle(); ex_memrd = 1; ex_rd = 0; d_rs1 = 0; apply();
        checks++; if (pc_wr_en !== 1'b1 || idex_flush !== 1'b0) begin errors++; $display("FAIL r0_nostall: got pc %b idexf %b want 1 0", pc_wr_en, idex_flush); end
        tick(); ex_rd = 3; d_rs1 = 1; d_rs2 = 3; d_uses_rs2 = 0; apply();
        checks++; if (pc_wr_en !== 1'b1 || hz_state !== 2'd0) begin errors++; $display("FAIL rs2_unused: got pc %b state %0d want 1 0", pc_wr_en, hz_state); end
        d_uses_rs2 = 1; apply();
        checks++; if (pc_wr_en !== 1'b0 || idex_flush !== 1'b1) begin errors++; $display("FAIL rs2_used: got pc %b idexf %b want 0 1", pc_wr_en, idex_flush); end
        tick(); set_idle(); tick();
    endtask

    task automatic test_async_reset();
        set_idle(); ex_branch_taken = 1; apply(); tick();
        ex_branch_taken = 0; ex_rs1 = 7; mem_rd = 7; mem_regwr = 1; apply();
        checks++; if (hz_state !== 2'd2) begin errors++; $display("FAIL ar_inflush: got %0d want 2", hz_state); end
        #1 rst = 1; #1;
        checks++; if ({pc_wr_en, ifid_wr_en, ifid_flush, idex_flush, pipe_hold} !== 5'b00110 || fwd_a !== 2'b00 || hz_state !== 2'd0) begin errors++; $display("FAIL ar_immediate: got ctl %b%b%b%b%b fwd %b state %0d want 00110 00 0", pc_wr_en, ifid_wr_en, ifid_flush, idex_flush, pipe_hold, fwd_a, hz_state); end
        @(negedge clk); rst = 0; set_idle(); model_reset(); apply();
        checks++; if (hz_state !== 2'd0 || ifid_flush !== 1'b0 || pc_wr_en !== 1'b1) begin errors++; $display("FAIL ar_after: got state %0d flush %b pc %b want 0 0 1", hz_state, ifid_flush, pc_wr_en); end
`ifdef HAZARD_PERF_EN
        checks++; if (stall_cnt !== 0 || flush_cnt !== 0 || mwait_cnt !== 0) begin errors++; $display("FAIL ar_perf: got %0d %0d %0d want 0 0 0", stall_cnt, flush_cnt, mwait_cnt); end
`endif
        tick();
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 600; i++) begin
            d_rs1 = RW'($urandom_range(0, 3)); d_rs2 = RW'($urandom_range(0, 3));
            d_uses_rs2 = 1'($urandom_range(0, 1));
            ex_rs1 = RW'($urandom_range(0, 3)); ex_rs2 = RW'($urandom_range(0, 3));
            ex_rd = RW'($urandom_range(0, 3)); ex_memrd = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            mem_rd = RW'($urandom_range(0, 3)); mem_regwr = 1'($urandom_range(0, 1));
            wb_rd = RW'($urandom_range(0, 3)); wb_regwr = 1'($urandom_range(0, 1));
            mem_busy = ($urandom_range(0, 5) == 0);
            apply();
            checks++;
            if ({pc_wr_en, ifid_wr_en, ifid_flush, idex_flush, pipe_hold} !== {e_pc, e_ifid, e_iff, e_idf, e_hold}
                || hz_state !== e_state || fwd_a !== e_fa || fwd_b !== e_fb) begin
                errors++;
                if (bad++ < 10)
                    $display("FAIL rand[%0d]: got ctl %b%b%b%b%b st %0d fa %b fb %b, want ctl %b%b%b%b%b st %0d fa %b fb %b",
                             i, pc_wr_en, ifid_wr_en, ifid_flush, idex_flush, pipe_hold, hz_state, fwd_a, fwd_b,
                             e_pc, e_ifid, e_iff, e_idf, e_hold, e_state, e_fa, e_fb);
            end
            tick();
        end
        set_idle();
`ifdef HAZARD_PERF_EN
        #1;
        checks++; if (stall_cnt !== 32'(m_stall)) begin errors++; $display("FAIL perf_stall: got %0d want %0d", stall_cnt, m_stall); end
        checks++; if (flush_cnt !== 32'(m_flushc)) begin errors++; $display("FAIL perf_flush: got %0d want %0d", flush_cnt, m_flushc); end
        checks++; if (mwait_cnt !== 32'(m_holdc)) begin errors++; $display("FAIL perf_mwait: got %0d want %0d", mwait_cnt, m_holdc); end
`endif
    endtask

    initial begin
        set_idle();
        model_reset();
        test_reset();
        test_load_use();
        test_branch();
        test_branch_busy();
        test_forwarding();
        test_reg0();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
